// File: rtl/mem_pkg.sv
// Shared types and constants for the LEGv8 MEM stage.
package mem_pkg;
   localparam int DATA_W     = 64;
   localparam int ALIGN_BITS = 3;

   typedef enum logic {IDLE, REQ} mem_state_t;

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] pc_branch;
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] write_data;
      logic              zero;
      logic              branch;
      logic              mem_read;
      logic              mem_write;
      logic              reg_write;
      logic              memto_reg;
      logic [4:0]        rd;
   } exmem_t;

   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic              memto_reg;
      logic              misaligned;
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] read_data;
      logic [4:0]        rd;
   } memwb_t;
endpackage

// File: rtl/flopre.sv
// Parameterised register with synchronous reset (priority) and load enable.
module flopre #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk) begin
      if (reset)   q <= '0;
      else if (en) q <= d;
   end
endmodule

// File: rtl/memory_access.sv
// LEGv8 MEM stage: EX/MEM register, branch resolve, req/ack data-memory
// handshake with upstream stall, and MEM/WB register.
module memory_access
   import mem_pkg::*;
#(
   parameter int size       = mem_pkg::DATA_W,
   parameter int ALIGN_BITS = mem_pkg::ALIGN_BITS
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_E,
   input  logic [size-1:0] PCBranch_E,
   input  logic [size-1:0] aluResult_E,
   input  logic [size-1:0] writeData_E,
   input  logic            zero_E,
   input  logic            Branch_E,
   input  logic            MemRead_E,
   input  logic            MemWrite_E,
   input  logic            regWrite_E,
   input  logic            memtoReg_E,
   input  logic [4:0]      rd_E,
   output logic            stall_M,
   output logic            PCSrc_M,
   output logic [size-1:0] PCBranch_M,
   output logic            dm_req,
   output logic            dm_we,
   output logic [size-1:0] dm_addr,
   output logic [size-1:0] dm_wdata,
   input  logic            dm_ack,
   input  logic [size-1:0] dm_rdata,
   output logic            valid_W,
   output logic            regWrite_W,
   output logic            memtoReg_W,
   output logic            misaligned_W,
   output logic [size-1:0] aluResult_W,
   output logic [size-1:0] readData_W,
   output logic [4:0]      rd_W
);
   exmem_t     m_d, m_q;
   memwb_t     w_d, w_q;
   mem_state_t state, cur_state;
   logic       mem_op, misaligned, pending, m_en;

   always_comb begin
      m_d            = '0;
      m_d.valid      = valid_E;
      m_d.pc_branch  = PCBranch_E;
      m_d.alu_result = aluResult_E;
      m_d.write_data = writeData_E;
      m_d.zero       = zero_E;
      m_d.branch     = Branch_E;
      m_d.mem_read   = MemRead_E;
      m_d.mem_write  = MemWrite_E;
      m_d.reg_write  = regWrite_E;
      m_d.memto_reg  = memtoReg_E;
      m_d.rd         = rd_E;
   end

   assign m_en = !stall_M;

   flopre #(.WIDTH($bits(exmem_t))) m_reg (
      .clk(clk), .reset(reset), .en(m_en), .d(m_d), .q(m_q)
   );

   assign mem_op     = m_q.valid & (m_q.mem_read | m_q.mem_write);
   assign misaligned = mem_op & (m_q.alu_result[ALIGN_BITS-1:0] != '0);
   assign pending    = mem_op & !misaligned;

   // M holds while stalled, so the request fields stay stable until the ack edge;
   // REQ is entered in the same cycle the aligned op appears in M.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= (pending && !dm_ack) ? REQ : IDLE;
   end

   assign cur_state = (state == REQ || pending) ? REQ : IDLE;
   assign dm_req    = (cur_state == REQ);
   assign dm_we     = dm_req & m_q.mem_write;
   assign dm_addr   = dm_req ? m_q.alu_result : '0;
   assign dm_wdata  = dm_req ? m_q.write_data : '0;
   assign stall_M   = pending & !dm_ack;

   assign PCSrc_M    = m_q.valid & m_q.branch & m_q.zero;
   assign PCBranch_M = m_q.pc_branch;

   // A stall edge writes a bubble into W; otherwise M retires into W.
   always_comb begin
      w_d = '0;
      if (!stall_M) begin
         w_d.valid      = m_q.valid;
         w_d.reg_write  = m_q.reg_write & !misaligned;
         w_d.memto_reg  = m_q.memto_reg;
         w_d.misaligned = misaligned;
         w_d.alu_result = m_q.alu_result;
         w_d.read_data  = (pending && m_q.mem_read && !m_q.mem_write) ? dm_rdata : '0;
         w_d.rd         = m_q.rd;
      end
   end

   flopre #(.WIDTH($bits(memwb_t))) w_reg (
      .clk(clk), .reset(reset), .en(1'b1), .d(w_d), .q(w_q)
   );

   assign valid_W      = w_q.valid;
   assign regWrite_W   = w_q.reg_write;
   assign memtoReg_W   = w_q.memto_reg;
   assign misaligned_W = w_q.misaligned;
   assign aluResult_W  = w_q.alu_result;
   assign readData_W   = w_q.read_data;
   assign rd_W         = w_q.rd;
endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for the memory_access MEM stage.
module tb_memory_access;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        valid_E = 1'b0;
   logic [63:0] PCBranch_E = '0, aluResult_E = '0, writeData_E = '0;
   logic        zero_E = 1'b0, Branch_E = 1'b0, MemRead_E = 1'b0, MemWrite_E = 1'b0;
   logic        regWrite_E = 1'b0, memtoReg_E = 1'b0;
   logic [4:0]  rd_E = '0;
   logic        stall_M, PCSrc_M, dm_req, dm_we;
   logic [63:0] PCBranch_M, dm_addr, dm_wdata;
   logic        dm_ack = 1'b0;
   logic [63:0] dm_rdata = '0;
   logic        valid_W, regWrite_W, memtoReg_W, misaligned_W;
   logic [63:0] aluResult_W, readData_W;
   logic [4:0]  rd_W;

   int total = 0;
   int bad   = 0;

   memory_access #(.size(64), .ALIGN_BITS(3)) dut (
      .clk(clk), .reset(reset), .valid_E(valid_E), .PCBranch_E(PCBranch_E),
      .aluResult_E(aluResult_E), .writeData_E(writeData_E), .zero_E(zero_E),
      .Branch_E(Branch_E), .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E),
      .regWrite_E(regWrite_E), .memtoReg_E(memtoReg_E), .rd_E(rd_E),
      .stall_M(stall_M), .PCSrc_M(PCSrc_M), .PCBranch_M(PCBranch_M),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata), .valid_W(valid_W),
      .regWrite_W(regWrite_W), .memtoReg_W(memtoReg_W), .misaligned_W(misaligned_W),
      .aluResult_W(aluResult_W), .readData_W(readData_W), .rd_W(rd_W)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_e(input logic v, input logic br, input logic mr, input logic mw,
                          input logic rw, input logic mtr, input logic [63:0] pcb,
                          input logic [63:0] alu, input logic [63:0] wd,
                          input logic z, input logic [4:0] rd);
      valid_E = v; Branch_E = br; MemRead_E = mr; MemWrite_E = mw;
      regWrite_E = rw; memtoReg_E = mtr; PCBranch_E = pcb;
      aluResult_E = alu; writeData_E = wd; zero_E = z; rd_E = rd;
   endtask

   task automatic clear_e();
      drive_e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 5'd0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      total++; if (dm_req !== 1'b0) begin bad++; $display("FAIL reset_dm_req got=%0h exp=0", dm_req); end
      total++; if (stall_M !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0h exp=0", stall_M); end
      total++; if (valid_W !== 1'b0) begin bad++; $display("FAIL reset_valid_W got=%0h exp=0", valid_W); end
      total++; if (PCBranch_M !== 64'h0) begin bad++; $display("FAIL reset_PCBranch_M got=%0h exp=0", PCBranch_M); end
      total++; if (aluResult_W !== 64'h0) begin bad++; $display("FAIL reset_aluResult_W got=%0h exp=0", aluResult_W); end
      reset = 1'b0;
   endtask

   task automatic test_reset_during_req();
      drive_e(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, '0, 64'h40, '0, 1'b0, 5'd3);
      tick();
      clear_e(); dm_ack = 1'b0; #1;
      total++; if (dm_req !== 1'b1) begin bad++; $display("FAIL rreq_wait1_req got=%0h exp=1", dm_req); end
      total++; if (dm_addr !== 64'h40) begin bad++; $display("FAIL rreq_addr got=%0h exp=40", dm_addr); end
      tick();
      total++; if (stall_M !== 1'b1) begin bad++; $display("FAIL rreq_wait2_stall got=%0h exp=1", stall_M); end
      reset = 1'b1;
      tick();
      reset = 1'b0; #1;
      total++; if (dm_req !== 1'b0) begin bad++; $display("FAIL rreq_after_rst_req got=%0h exp=0", dm_req); end
      total++; if (stall_M !== 1'b0) begin bad++; $display("FAIL rreq_after_rst_stall got=%0h exp=0", stall_M); end
      dm_ack = 1'b1; dm_rdata = 64'h1234; #1;
      total++; if (dm_req !== 1'b0) begin bad++; $display("FAIL rreq_late_ack_req got=%0h exp=0", dm_req); end
      tick();
      dm_ack = 1'b0;
      total++; if (valid_W !== 1'b0) begin bad++; $display("FAIL rreq_late_ack_valid_W got=%0h exp=0", valid_W); end
      total++; if (readData_W !== 64'h0) begin bad++; $display("FAIL rreq_late_ack_rdata got=%0h exp=0", readData_W); end
   endtask

   task automatic test_load_wait();
      int req_cnt = 0;
      int stall_cnt = 0;
      drive_e(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, '0, 64'h100, '0, 1'b0, 5'd5);
      tick();
      clear_e();
      for (int c = 1; c <= 3; c++) begin
         dm_ack   = (c == 3);
         dm_rdata = (c == 3) ? 64'hDEADBEEF : 64'h0;
         #1;
         if (dm_req === 1'b1) req_cnt++;
         if (stall_M === 1'b1) stall_cnt++;
         if (c == 1) begin
            total++; if (dm_we !== 1'b0) begin bad++; $display("FAIL load_we got=%0h exp=0", dm_we); end
            total++; if (dm_addr !== 64'h100) begin bad++; $display("FAIL load_addr got=%0h exp=100", dm_addr); end
         end
         if (c == 2) begin
            total++; if (valid_W !== 1'b0) begin bad++; $display("FAIL load_bubble_valid_W got=%0h exp=0", valid_W); end
         end
         tick();
      end
      dm_ack = 1'b0; dm_rdata = '0; #1;
      total++; if (req_cnt != 3) begin bad++; $display("FAIL load_req_cycles got=%0d exp=3", req_cnt); end
      total++; if (stall_cnt != 2) begin bad++; $display("FAIL load_stall_cycles got=%0d exp=2", stall_cnt); end
      total++; if (valid_W !== 1'b1) begin bad++; $display("FAIL load_valid_W got=%0h exp=1", valid_W); end
      total++; if (readData_W !== 64'hDEADBEEF) begin bad++; $display("FAIL load_rdata got=%0h exp=deadbeef", readData_W); end
      total++; if (rd_W !== 5'd5) begin bad++; $display("FAIL load_rd_W got=%0d exp=5", rd_W); end
      total++; if (memtoReg_W !== 1'b1) begin bad++; $display("FAIL load_memtoReg_W got=%0h exp=1", memtoReg_W); end
      total++; if (dm_req !== 1'b0) begin bad++; $display("FAIL load_req_drop got=%0h exp=0", dm_req); end
   endtask

   task automatic test_back_to_back();
      drive_e(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 64'h08, 64'h55, 1'b0, 5'd0);
      tick();
      drive_e(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, '0, 64'h08, '0, 1'b0, 5'd6);
      dm_ack = 1'b1; #1;
      total++; if (dm_req !== 1'b1) begin bad++; $display("FAIL b2b_st_req got=%0h exp=1", dm_req); end
      total++; if (dm_we !== 1'b1) begin bad++; $display("FAIL b2b_st_we got=%0h exp=1", dm_we); end
      total++; if (dm_wdata !== 64'h55) begin bad++; $display("FAIL b2b_st_wdata got=%0h exp=55", dm_wdata); end
      total++; if (stall_M !== 1'b0) begin bad++; $display("FAIL b2b_st_stall got=%0h exp=0", stall_M); end
      tick();
      clear_e(); dm_ack = 1'b1; dm_rdata = 64'h55; #1;
      total++; if (valid_W !== 1'b1 || readData_W !== 64'h0 || regWrite_W !== 1'b0) begin
         bad++; $display("FAIL b2b_st_W got=v%0h rd%0h rw%0h exp=v1 rd0 rw0", valid_W, readData_W, regWrite_W);
      end
      total++; if (dm_req !== 1'b1) begin bad++; $display("FAIL b2b_ld_req got=%0h exp=1", dm_req); end
      total++; if (dm_we !== 1'b0) begin bad++; $display("FAIL b2b_ld_we got=%0h exp=0", dm_we); end
      total++; if (stall_M !== 1'b0) begin bad++; $display("FAIL b2b_ld_stall got=%0h exp=0", stall_M); end
      tick();
      dm_ack = 1'b0; dm_rdata = '0; #1;
      total++; if (readData_W !== 64'h55) begin bad++; $display("FAIL b2b_ld_rdata got=%0h exp=55", readData_W); end
      total++; if (rd_W !== 5'd6 || regWrite_W !== 1'b1) begin bad++; $display("FAIL b2b_ld_rd got=%0d rw%0h exp=6 rw1", rd_W, regWrite_W); end
   endtask

   task automatic test_read_write_both();
      drive_e(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 64'h18, 64'h77, 1'b0, 5'd2);
      tick();
      clear_e(); dm_ack = 1'b1; dm_rdata = 64'hABCD; #1;
      total++; if (dm_we !== 1'b1) begin bad++; $display("FAIL rw_both_we got=%0h exp=1", dm_we); end
      tick();
      dm_ack = 1'b0; dm_rdata = '0;
      total++; if (readData_W !== 64'h0 || valid_W !== 1'b1) begin bad++; $display("FAIL rw_both_rdata got=%0h v%0h exp=0 v1", readData_W, valid_W); end
   endtask

   task automatic test_misaligned();
      drive_e(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, '0, 64'h103, '0, 1'b0, 5'd7);
      tick();
      clear_e(); dm_ack = 1'b0; dm_rdata = 64'h9999; #1;
      total++; if (dm_req !== 1'b0) begin bad++; $display("FAIL mis_req got=%0h exp=0", dm_req); end
      total++; if (stall_M !== 1'b0) begin bad++; $display("FAIL mis_stall got=%0h exp=0", stall_M); end
      tick();
      dm_rdata = '0;
      total++; if (misaligned_W !== 1'b1) begin bad++; $display("FAIL mis_flag got=%0h exp=1", misaligned_W); end
      total++; if (regWrite_W !== 1'b0) begin bad++; $display("FAIL mis_regWrite got=%0h exp=0", regWrite_W); end
      total++; if (valid_W !== 1'b1 || readData_W !== 64'h0) begin bad++; $display("FAIL mis_W got=v%0h rd%0h exp=v1 rd0", valid_W, readData_W); end
      total++; if (aluResult_W !== 64'h103) begin bad++; $display("FAIL mis_alu got=%0h exp=103", aluResult_W); end
   endtask

   task automatic test_alu_latency();
      drive_e(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 64'h1234, '0, 1'b0, 5'd9);
      tick();
      clear_e();
      total++; if (dm_req !== 1'b0) begin bad++; $display("FAIL alu_req got=%0h exp=0", dm_req); end
      tick();
      total++; if (valid_W !== 1'b1 || regWrite_W !== 1'b1 || misaligned_W !== 1'b0) begin
         bad++; $display("FAIL alu_ctrl got=v%0h rw%0h mis%0h exp=v1 rw1 mis0", valid_W, regWrite_W, misaligned_W);
      end
      total++; if (aluResult_W !== 64'h1234 || rd_W !== 5'd9) begin bad++; $display("FAIL alu_data got=%0h rd%0d exp=1234 rd9", aluResult_W, rd_W); end
      tick();
      total++; if (valid_W !== 1'b0) begin bad++; $display("FAIL alu_bubble got=%0h exp=0", valid_W); end
   endtask

   task automatic test_branch();
      drive_e(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h200, '0, '0, 1'b1, 5'd0);
      tick();
      clear_e();
      total++; if (PCSrc_M !== 1'b1) begin bad++; $display("FAIL br_taken got=%0h exp=1", PCSrc_M); end
      total++; if (PCBranch_M !== 64'h200) begin bad++; $display("FAIL br_target got=%0h exp=200", PCBranch_M); end
      tick();
      total++; if (PCSrc_M !== 1'b0) begin bad++; $display("FAIL br_one_cycle got=%0h exp=0", PCSrc_M); end
      drive_e(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h200, 64'h1, '0, 1'b0, 5'd0);
      tick();
      clear_e();
      total++; if (PCSrc_M !== 1'b0) begin bad++; $display("FAIL br_not_taken got=%0h exp=0", PCSrc_M); end
      drive_e(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h300, '0, '0, 1'b1, 5'd0);
      tick();
      clear_e();
      total++; if (PCSrc_M !== 1'b0) begin bad++; $display("FAIL br_invalid got=%0h exp=0", PCSrc_M); end
   endtask

   initial begin
      test_reset();
      test_reset_during_req();
      test_load_wait();
      test_back_to_back();
      test_read_write_both();
      test_misaligned();
      test_alu_latency();
      test_branch();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Pipelined MEM stage of the 64-bit LEGv8 datapath; sits directly downstream of the execute stage.
- Registers execute outputs into an internal EX/MEM register and resolves the conditional branch (PCSrc_M).
- Runs a req/ack handshake to a variable-latency data memory, stalling upstream while it waits.
- Registers results into a MEM/WB register for writeback.

Parameters:
- size, 64, datapath width in bits.
- ALIGN_BITS, 3, low address bits that must be zero for a legal doubleword access.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- valid_E  in  1  execute slot holds a real instruction
- PCBranch_E  in  size  branch target from execute
- aluResult_E  in  size  ALU result / effective address
- writeData_E  in  size  store data
- zero_E  in  1  ALU zero flag
- Branch_E, MemRead_E, MemWrite_E, regWrite_E, memtoReg_E  in  1 each  control bits
- rd_E  in  5  destination register
- stall_M  out  1  hold execute and earlier stages
- PCSrc_M  out  1  take branch
- PCBranch_M  out  size  registered branch target
- dm_req  out  1  memory request
- dm_we  out  1  1 = write
- dm_addr  out  size  request address
- dm_wdata  out  size  write data
- dm_ack  in  1  memory completion
- dm_rdata  in  size  read data, valid with dm_ack
- valid_W, regWrite_W, memtoReg_W, misaligned_W  out  1 each  writeback controls and error flag
- aluResult_W, readData_W  out  size  writeback data
- rd_W  out  5  writeback destination

Behaviour:
- Reset: all registers, FSM and outputs go to 0 on the first rising clk with reset high.
  - Applies mid-transaction: an outstanding dm_req drops the next cycle.
  - A later dm_ack in IDLE is ignored.
- EX/MEM register (M): loads all *_E inputs every edge where stall_M=0; holds otherwise.
- A memory op is valid_M & (MemRead_M | MemWrite_M).
- Misaligned: memory op with aluResult_M[ALIGN_BITS-1:0] != 0.
- FSM states are IDLE and REQ.
  - IDLE -> REQ: an aligned memory op is in M. REQ is entered combinationally in the same cycle M holds it; the request is visible that cycle.
  - REQ: dm_req=1; dm_addr=aluResult_M; dm_wdata=writeData_M; dm_we=MemWrite_M. These hold stable until dm_ack is sampled high.
  - REQ -> IDLE: on the edge where dm_ack=1.
  - dm_req=0 in IDLE. Zero-wait memory (dm_ack high in the first REQ cycle) completes in that cycle.
- stall_M = memory-op-pending & !dm_ack. On the ack edge, M accepts the next instruction and W loads the result simultaneously, giving back-to-back accesses with no bubble.
- MemRead and MemWrite both set: treated as a write; readData_W=0.
- Misaligned op: no dm_req, no stall. W loads with misaligned_W=1, regWrite_W forced 0, readData_W=0.
- MEM/WB register (W):
  - Loads every edge M retires: a non-memory or misaligned instruction retires immediately; a memory op retires on its ack edge.
  - On a stall edge, W loads a bubble: valid_W=0, regWrite_W=0.
  - readData_W = dm_rdata captured on the ack edge; 0 for non-reads.
  - Other W fields copy M.
- Latency: a non-memory instruction reaches W one edge after entering M. A memory op reaches W on its ack edge.
- Branch: PCSrc_M = valid_M & Branch_M & zero_M, combinational from the M register, asserted exactly one cycle. PCBranch_M = registered PCBranch_E.
- valid_E=0 loads a bubble into M: no request, PCSrc_M=0.

Decomposition:
- Shared package mem_pkg:
  - typedef enum mem_state_t {IDLE, REQ};
  - constant ALIGN_BITS;
  - packed struct exmem_t and memwb_t for the pipeline register contents.
- One sub-module, flopre: a parameterised flop with synchronous reset and enable. Instantiate it twice, for the M and W registers.

Test Plan:
- Reset during REQ: LDUR to 0x40, hold dm_ack=0, assert reset in the 2nd wait cycle -> dm_req=0 and stall_M=0 next cycle. An ack pulse in the following cycle is ignored; valid_W stays 0.
- Load, 3-cycle memory: LDUR with aluResult_E=0x100, rd=5; dm_ack rises on the 3rd REQ cycle with dm_rdata=0xDEADBEEF -> dm_req high 3 cycles, stall_M high 2 cycles. On the ack edge: valid_W=1, readData_W=0xDEADBEEF, rd_W=5, memtoReg_W=1.
- Back-to-back with zero-wait ack: STUR to 0x08 (wdata=0x55) then LDUR from 0x08 (rdata=0x55) -> two requests on consecutive cycles, dm_we 1 then 0, stall_M never asserted, readData_W=0x55.
- Misaligned: LDUR with aluResult_E=0x103 -> no dm_req, misaligned_W=1, regWrite_W=0, stall_M=0.
- Branch: CBZ with zero_E=1, PCBranch_E=0x200 -> PCSrc_M=1 for exactly one cycle with PCBranch_M=0x200. With zero_E=0 -> PCSrc_M stays 0.
